// File: rtl/sap_pkg.sv
// Shared SAP definitions: bus/address defaults, PC command codes, clog2 helper.
// Used by sap_program_counter_stack and sap_lifo.
package sap_pkg;

    localparam int SAP_ADDR_W      = 4;
    localparam int SAP_BUS_W       = 8;
    localparam int SAP_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_RET,
        CMD_CALL,
        CMD_JUMP,
        CMD_INC
    } pc_cmd_e;

    // Minimum 1 bit so that single-entry structures still get a port.
    function automatic int sap_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sap_lifo.sv
// Return-address LIFO for the SAP program counter.
// Index-addressed register array; contents are not reset.
module sap_lifo
    import sap_pkg::*;
#(
    parameter  int WIDTH = SAP_ADDR_W,
    parameter  int DEPTH = SAP_STACK_DEPTH,
    parameter  int CNT_W = sap_clog2(DEPTH + 1),
    localparam int IDX_W = sap_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign wr_idx = IDX_W'(count_q);
    assign rd_idx = IDX_W'(count_q - CNT_W'(1));
    assign dout   = mem_q[rd_idx];

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            count_d       = count_q + CNT_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sap_program_counter_stack.sv
// SAP program counter: increment, jump, bus tri-state driver, wrap pulse.
// CALL/RET return stack and sticky error flags built only with SAP_PC_CALL_STACK_EN.
module sap_program_counter_stack
    import sap_pkg::*;
#(
    parameter  int ADDR_W      = SAP_ADDR_W,
    parameter  int BUS_W       = SAP_BUS_W,
    parameter  int STACK_DEPTH = SAP_STACK_DEPTH,
    localparam int SP_W        = sap_clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    inout  wire  [BUS_W-1:0]  DATA,
    output logic [ADDR_W-1:0] REG_OUT,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic              output_enable,
    input  logic              counter_enable,
    input  logic              clear_err,
    output logic              wrap,
    output logic              stack_ovf,
    output logic              stack_unf,
    output logic [SP_W-1:0]   sp
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              wrap_q;
    logic              wrap_d;
    logic [ADDR_W-1:0] bus_addr;
    logic [ADDR_W-1:0] stack_top;
    logic              call_req;
    logic              ret_req;
    logic              push;
    logic              pop;
    pc_cmd_e           cmd;
    logic              unused_in;

    assign bus_addr  = DATA[ADDR_W-1:0];
    assign unused_in = ^{DATA, call, ret, clear_err};

`ifdef SAP_PC_CALL_STACK_EN
    logic            full;
    logic            empty;
    logic [SP_W-1:0] count;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;

    assign call_req = call;
    assign ret_req  = ret;
    assign push     = (cmd == CMD_CALL) && !full;
    assign pop      = (cmd == CMD_RET) && !empty;

    sap_lifo #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH),
        .CNT_W (SP_W)
    ) u_lifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_q),
        .dout  (stack_top),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A new error in the same cycle as clear_err keeps the flag set.
    always_comb begin
        ovf_d = ((cmd == CMD_CALL) && full) || (ovf_q && !clear_err);
        unf_d = ((cmd == CMD_RET) && empty) || (unf_q && !clear_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign sp        = count;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;
`else
    assign call_req  = 1'b0;
    assign ret_req   = 1'b0;
    assign push      = 1'b0;
    assign pop       = 1'b0;
    assign stack_top = '0;
    assign sp        = '0;
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

    always_comb begin
        cmd = CMD_NONE;
        priority case (1'b1)
            ret_req:        cmd = CMD_RET;
            call_req:       cmd = CMD_CALL;
            jump:           cmd = CMD_JUMP;
            counter_enable: cmd = CMD_INC;
            default:        cmd = CMD_NONE;
        endcase
    end

    always_comb begin
        pc_d   = pc_q;
        wrap_d = 1'b0;
        unique case (cmd)
            CMD_RET: begin
                if (pop) pc_d = stack_top;
            end
            CMD_CALL: begin
                if (push) pc_d = bus_addr;
            end
            CMD_JUMP: pc_d = bus_addr;
            CMD_INC: begin
                pc_d   = pc_q + 1'b1;
                wrap_d = &pc_q;
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= '0;
            wrap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            wrap_q <= wrap_d;
        end
    end

    assign REG_OUT = pc_q;
    assign wrap    = wrap_q;
    assign DATA    = output_enable ? BUS_W'(pc_q) : {BUS_W{1'bz}};

endmodule

// File: tb/tb_sap_program_counter_stack.sv
// Self-checking bench for sap_program_counter_stack (ADDR_W=4, BUS_W=8, depth 4).
// Vector table, hand sequences and randomized run against a queue-based model.
module tb_sap_program_counter_stack;

`ifdef SAP_PC_CALL_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       jump, call, ret, oe, ce, clr;
    logic       tb_drv;
    logic [7:0] tb_data;
    wire  [7:0] data_bus;
    logic [3:0] reg_out;
    logic       wrap, ovf, unf;
    logic [2:0] sp;

    assign data_bus = tb_drv ? tb_data : 8'bz;

    sap_program_counter_stack #(
        .ADDR_W      (4),
        .BUS_W       (8),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .DATA           (data_bus),
        .REG_OUT        (reg_out),
        .jump           (jump),
        .call           (call),
        .ret            (ret),
        .output_enable  (oe),
        .counter_enable (ce),
        .clear_err      (clr),
        .wrap           (wrap),
        .stack_ovf      (ovf),
        .stack_unf      (unf),
        .sp             (sp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_pc;
    int m_stack[$];
    bit m_wrap, m_ovf, m_unf;

    typedef struct {
        logic       ce;
        logic       j;
        logic       oe;
        logic [7:0] d;
        int         pc;
        int         wr;
        bit         chk_data;
        int         dval;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic c_e, input logic j, input logic c,
                         input logic r, input logic cl, input logic o,
                         input logic [7:0] d);
        ce = c_e; jump = j; call = c; ret = r; clr = cl; oe = o;
        tb_drv = !o;
        tb_data = d;
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stack.delete();
        m_wrap = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic model_step();
        int bus;
        bit set_o, set_u;
        bus = oe ? m_pc : int'(tb_data);
        set_o = 0;
        set_u = 0;
        m_wrap = 0;
        if (STK && ret) begin
            if (m_stack.size() == 0) set_u = 1;
            else m_pc = m_stack.pop_back();
        end else if (STK && call) begin
            if (m_stack.size() == DEPTH) set_o = 1;
            else begin
                m_stack.push_back(m_pc);
                m_pc = bus % 16;
            end
        end else if (jump) begin
            m_pc = bus % 16;
        end else if (ce) begin
            m_wrap = (m_pc == 15);
            m_pc = (m_pc + 1) % 16;
        end
        if (STK) begin
            m_ovf = set_o || (m_ovf && !clr);
            m_unf = set_u || (m_unf && !clr);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string t, input int pc, input int s,
                                input int w, input int o, input int u);
        check({t, ".pc"}, int'(reg_out), pc);
        check({t, ".sp"}, int'(sp), s);
        check({t, ".wrap"}, int'(wrap), w);
        check({t, ".ovf"}, int'(ovf), o);
        check({t, ".unf"}, int'(unf), u);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1,  0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 2,  0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3,  0, 1'b0, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'hA9, 9,  0, 1'b0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h0E, 14, 0, 1'b0, 0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h00, 15, 0, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0,  1, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 0,  0, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h05, 5,  0, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 5,  0, 1'b1, 8'h05};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h3C, 5,  0, 1'b1, 8'h3C};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 5,  0, 1'b1, 8'h05};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 6,  0, 1'b1, 8'h06};

        apply(0, 0, 0, 0, 0, 0, 8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        expect_state("reset", 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        cycle();
        expect_state("post_reset", 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 8'h00);
        repeat (3) cycle();
        expect_state("count3", 3, 0, 0, 0, 0);

        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset.pc", int'(reg_out), 0);
        @(posedge clk);
        #1;
        check("hold_reset.pc", int'(reg_out), 0);
        reset_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].ce, tbl[i].j, 0, 0, 0, tbl[i].oe, tbl[i].d);
            cycle();
            check($sformatf("vec%0d.pc", i), int'(reg_out), tbl[i].pc);
            check($sformatf("vec%0d.wrap", i), int'(wrap), tbl[i].wr);
            check($sformatf("vec%0d.sp", i), int'(sp), 0);
            if (tbl[i].chk_data)
                check($sformatf("vec%0d.data", i), int'(data_bus), tbl[i].dval);
        end

        apply(0, 1, 0, 0, 0, 0, 8'h03);
        cycle();
        expect_state("jmp3", 3, 0, 0, 0, 0);
`ifdef SAP_PC_CALL_STACK_EN
        apply(0, 0, 1, 0, 0, 0, 8'h08);
        cycle();
        expect_state("call8", 8, 1, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 8'h0C);
        cycle();
        expect_state("callC", 12, 2, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 8'h00);
        cycle();
        expect_state("ret1", 8, 1, 0, 0, 0);
        cycle();
        expect_state("ret2", 3, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            apply(0, 0, 1, 0, 0, 0, 8'(i));
            cycle();
            if (i < 5) expect_state($sformatf("fill%0d", i), i, i, 0, 0, 0);
        end
        expect_state("overflow", 4, 4, 0, 1, 0);
        apply(0, 0, 0, 1, 0, 0, 8'h00);
        cycle();
        expect_state("pop1", 3, 3, 0, 1, 0);
        cycle();
        expect_state("pop2", 2, 2, 0, 1, 0);
        cycle();
        expect_state("pop3", 1, 1, 0, 1, 0);
        cycle();
        expect_state("pop4", 3, 0, 0, 1, 0);
        cycle();
        expect_state("underflow", 3, 0, 0, 1, 1);
        apply(0, 0, 0, 1, 1, 0, 8'h00);
        cycle();
        expect_state("clr_vs_set", 3, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 1, 0, 8'h00);
        cycle();
        expect_state("clear", 3, 0, 0, 0, 0);
`else
        apply(0, 0, 1, 0, 0, 0, 8'h08);
        cycle();
        expect_state("call_off", 3, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0, 8'h00);
        cycle();
        expect_state("ret_off", 3, 0, 0, 0, 0);
`endif

        for (int n = 0; n < 800; n++) begin
            apply(1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0,
                  8'($urandom));
            cycle();
            check("rnd.pc", int'(reg_out), m_pc);
            check("rnd.sp", int'(sp), m_stack.size());
            check("rnd.wrap", int'(wrap), int'(m_wrap));
            check("rnd.ovf", int'(ovf), int'(m_ovf));
            check("rnd.unf", int'(unf), int'(m_unf));
            if (oe) check("rnd.data", int'(data_bus), m_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
